// File: rtl/apb_slave_regs.sv
// APB completer with ID, WAIT_CFG and scratch registers; errors reported on pslverr.
// Optional wait states are enabled by defining APB_SLAVE_WAIT_EN.
`ifndef APB_ADDR_W
`define APB_ADDR_W 32
`endif
`ifndef APB_DATA_W
`define APB_DATA_W 32
`endif

module apb_slave_regs #(
  parameter int          ADDR_W   = `APB_ADDR_W,
  parameter int          DATA_W   = `APB_DATA_W,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VAL   = 32'hA5B0_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam int                NSCR       = NUM_REGS - 2;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * NUM_REGS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e            state_q;
  logic              err_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] scratch_q [NSCR];
  logic [3:0]        wait_cfg;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]        wait_cfg_q;
  logic [3:0]        wcnt_q;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] resp_data;

  assign wait_cfg  = wait_cfg_q;
  // Response presented once the wait count expires, built from the setup snapshot.
  assign resp_data = (!wr_q && !err_q) ? snap_q : '0;
`else
  assign wait_cfg  = 4'd0;
`endif

  logic [IDX_W-1:0]  idx;
  logic              dec_err;
  logic              setup_ok;
  logic              wait_zero;
  logic              commit;
  logic [DATA_W-1:0] rd_val;

  assign idx       = paddr[IDX_W+1:2];
  assign dec_err   = (paddr >= ADDR_LIMIT) || (paddr[1:0] != 2'b00) ||
                     (pwrite && (paddr == '0));
  assign setup_ok  = psel && !penable;
  assign wait_zero = (wait_cfg == 4'd0);
  assign commit    = (state_q == ST_ACCESS) && psel && penable && pready_q &&
                     wr_q && !err_q;

  always_comb begin
    rd_val = '0;
    if (idx == '0) begin
      rd_val = DATA_W'(ID_VAL);
    end else if (idx == IDX_W'(1)) begin
      rd_val = DATA_W'(wait_cfg);
    end else begin
      for (int i = 0; i < NSCR; i++) begin
        if (idx == IDX_W'(i + 2)) rd_val = scratch_q[i];
      end
    end
  end

  // Outputs are flops: they are loaded at setup when no wait is configured,
  // otherwise when the wait counter reaches its last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_SLAVE_WAIT_EN
      wcnt_q    <= 4'd0;
      snap_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setup_ok) begin
            state_q   <= ST_ACCESS;
            err_q     <= dec_err;
            wr_q      <= pwrite;
            idx_q     <= idx;
            pready_q  <= wait_zero;
            pslverr_q <= wait_zero && dec_err;
            prdata_q  <= (wait_zero && !pwrite && !dec_err) ? rd_val : '0;
`ifdef APB_SLAVE_WAIT_EN
            wcnt_q    <= wait_cfg_q;
            snap_q    <= rd_val;
`endif
          end
        end
        ST_ACCESS: begin
          if (!(psel && penable)) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else if (pready_q) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end
`ifdef APB_SLAVE_WAIT_EN
          else begin
            wcnt_q <= wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= resp_data;
            end
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
`ifdef APB_SLAVE_WAIT_EN
      wait_cfg_q <= 4'd0;
`endif
    end else if (commit) begin
`ifdef APB_SLAVE_WAIT_EN
      if (idx_q == IDX_W'(1)) wait_cfg_q <= pwdata[3:0];
`endif
      for (int i = 0; i < NSCR; i++) begin
        if (idx_q == IDX_W'(i + 2)) scratch_q[i] <= pwdata;
      end
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule
